// File: rtl/fwd_types_pkg.sv
// rtl/fwd_types_pkg.sv - shared types for the forwarding scoreboard
package fwd_types_pkg;

    localparam int REGW = 5;

    typedef logic [REGW-1:0] regbits_t;

    typedef struct packed {
        logic     valid;
        logic     wen;
        logic     is_load;
        regbits_t dest;
    } sb_entry_t;

    // Select code 0 means register file, k+1 means entry k.
    function automatic int fwdsel_width(input int nstages);
        return $clog2(nstages + 1);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_match.sv
// rtl/fwd_scoreboard_match.sv - per-port youngest-producer search over the scoreboard
module fwd_match import fwd_types_pkg::*; #(
    parameter int NSTAGES    = 2,
    parameter int LOAD_READY = 1,
    parameter int DW         = 32,
    parameter int SELW       = fwdsel_width(NSTAGES)
) (
    input  sb_entry_t [NSTAGES-1:0] entries_i,
    input  logic [REGW-1:0]         src_i,
    input  logic [NSTAGES*DW-1:0]   stage_data_i,
    output logic [SELW-1:0]         sel_o,
    output logic                    hazard_o,
    output logic [DW-1:0]           data_o
);

    // Walk oldest to youngest so the youngest match overwrites; a not-ready
    // young load therefore hides any older ready producer of the same register.
    always_comb begin
        sel_o    = '0;
        hazard_o = 1'b0;
        data_o   = '0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (src_i != '0 && entries_i[k].valid && entries_i[k].wen &&
                entries_i[k].dest == src_i) begin
                if (!entries_i[k].is_load || k >= LOAD_READY) begin
                    sel_o    = SELW'(k + 1);
                    hazard_o = 1'b0;
                    data_o   = stage_data_i[k*DW +: DW];
                end else begin
                    sel_o    = '0;
                    hazard_o = 1'b1;
                    data_o   = '0;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - shift-register scoreboard with forwarding, load-use stall and stall counter
module fwd_scoreboard import fwd_types_pkg::*; #(
    parameter int  NSTAGES     = 2,
    parameter int  NREAD       = 2,
    parameter int  LOAD_READY  = 1,
    parameter int  FLUSH_DEPTH = 1,
    parameter int  DW          = 32,
    localparam int SELW        = fwdsel_width(NSTAGES)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    advance,
    input  logic                    flush,
    input  logic                    issue_valid,
    input  logic                    issue_wen,
    input  logic                    issue_is_load,
    input  logic [REGW-1:0]         issue_dest,
    input  logic [NREAD*REGW-1:0]   issue_src,
    input  logic [NSTAGES*DW-1:0]   stage_data,
    output logic [NREAD*SELW-1:0]   fwd_sel,
    output logic [NREAD*DW-1:0]     fwd_data,
    output logic                    stall,
    output logic [31:0]             stall_cycles
);

    localparam int NFLUSH = (FLUSH_DEPTH < NSTAGES) ? FLUSH_DEPTH : NSTAGES;

    sb_entry_t [NSTAGES-1:0] entries_q, entries_d;
    sb_entry_t               issue_entry;
    logic [NREAD-1:0]        hazard;
    logic [31:0]             stall_cycles_q;
    logic                    count_en;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        fwd_match #(
            .NSTAGES    (NSTAGES),
            .LOAD_READY (LOAD_READY),
            .DW         (DW),
            .SELW       (SELW)
        ) u_match (
            .entries_i    (entries_q),
            .src_i        (issue_src[REGW*p +: REGW]),
            .stage_data_i (stage_data),
            .sel_o        (fwd_sel[SELW*p +: SELW]),
            .hazard_o     (hazard[p]),
            .data_o       (fwd_data[DW*p +: DW])
        );
    end

    assign stall = issue_valid && (|hazard);

    always_comb begin
        issue_entry = '0;
        if (issue_valid && !stall) begin
            issue_entry.valid   = 1'b1;
            issue_entry.wen     = issue_wen && (issue_dest != '0);
            issue_entry.is_load = issue_is_load;
            issue_entry.dest    = issue_dest;
        end
    end

    // Flush applies after the shift so it squashes the instruction that
    // would otherwise have landed in the youngest slots this edge.
    always_comb begin
        entries_d = entries_q;
        if (advance) begin
            for (int k = NSTAGES - 1; k >= 1; k--) begin
                entries_d[k] = entries_q[k-1];
            end
            entries_d[0] = issue_entry;
        end
        if (flush) begin
            for (int k = 0; k < NFLUSH; k++) begin
                entries_d[k].valid = 1'b0;
            end
        end
    end

    assign count_en = stall && advance && !flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            entries_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            entries_q <= entries_d;
            if (count_en && stall_cycles_q != 32'hFFFF_FFFF) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;

    localparam int NSTAGES     = 2;
    localparam int NREAD       = 2;
    localparam int LOAD_READY  = 1;
    localparam int FLUSH_DEPTH = 1;
    localparam int DW          = 32;
    localparam int SELW        = 2;
    localparam int NV          = 10;
    localparam int NRAND       = 3000;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic                  advance, flush, issue_valid, issue_wen, issue_is_load;
    logic [4:0]            issue_dest;
    logic [NREAD*5-1:0]    issue_src;
    logic [NSTAGES*DW-1:0] stage_data;
    logic [NREAD*SELW-1:0] fwd_sel;
    logic [NREAD*DW-1:0]   fwd_data;
    logic                  stall;
    logic [31:0]           stall_cycles;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    fwd_scoreboard #(
        .NSTAGES     (NSTAGES),
        .NREAD       (NREAD),
        .LOAD_READY  (LOAD_READY),
        .FLUSH_DEPTH (FLUSH_DEPTH),
        .DW          (DW)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .advance       (advance),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_wen     (issue_wen),
        .issue_is_load (issue_is_load),
        .issue_dest    (issue_dest),
        .issue_src     (issue_src),
        .stage_data    (stage_data),
        .fwd_sel       (fwd_sel),
        .fwd_data      (fwd_data),
        .stall         (stall),
        .stall_cycles  (stall_cycles)
    );

    typedef struct {
        logic        adv, fl, iv, iw, il;
        logic [4:0]  d, s0, s1;
        logic [1:0]  sel0, sel1;
        logic        stl;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        bit       valid, wen, is_load;
        bit [4:0] dest;
    } rec_t;

    vec_t vecs [NV];
    rec_t pipe [$];
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic adv, fl, iv, iw, il, input int d, s0, s1,
                                input int sel0, sel1, input logic stl, input int cnt);
        vec_t v;
        v.adv = adv; v.fl = fl; v.iv = iv; v.iw = iw; v.il = il;
        v.d = 5'(d); v.s0 = 5'(s0); v.s1 = 5'(s1);
        v.sel0 = 2'(sel0); v.sel1 = 2'(sel1); v.stl = stl; v.cnt = 32'(cnt);
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input int sel);
        if (sel == 0) return 32'h0;
        return stage_data[(sel-1)*DW +: DW];
    endfunction

    task automatic drive(input logic adv, fl, iv, iw, il, input int d, s0, s1);
        advance = adv; flush = fl; issue_valid = iv; issue_wen = iw; issue_is_load = il;
        issue_dest = 5'(d);
        issue_src  = {5'(s1), 5'(s0)};
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string name, input int sel0, input logic stl, input int cnt);
        check({name, " sel0"}, 64'(fwd_sel[1:0]), 64'(sel0));
        check({name, " data0"}, 64'(fwd_data[31:0]), 64'(exp_data(sel0)));
        check({name, " stall"}, 64'(stall), 64'(stl));
        check({name, " cnt"}, 64'(stall_cycles), 64'(cnt));
    endtask

    // Reference: pipe[i] is the instruction i stages past EX; search youngest first.
    task automatic model_port(input bit [4:0] src, output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        if (src != 0) begin
            for (int i = 0; i < pipe.size(); i++) begin
                if (pipe[i].valid && pipe[i].wen && pipe[i].dest == src) begin
                    if (pipe[i].is_load && i < LOAD_READY) haz = 1'b1;
                    else sel = i + 1;
                    break;
                end
            end
        end
    endtask

    initial begin
        vecs[0] = mk(1, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(1, 0, 1, 1, 0, 5, 3, 0, 1, 0, 0, 0);
        vecs[2] = mk(1, 0, 1, 1, 0, 5, 3, 5, 2, 1, 0, 0);
        vecs[3] = mk(1, 0, 1, 1, 1, 7, 5, 5, 1, 1, 0, 0);
        vecs[4] = mk(1, 0, 1, 0, 0, 0, 7, 5, 0, 2, 1, 0);
        vecs[5] = mk(1, 0, 1, 0, 0, 0, 7, 0, 2, 0, 0, 1);
        vecs[6] = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[7] = mk(1, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 1);
        vecs[8] = mk(1, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 1);
        vecs[9] = mk(1, 0, 1, 0, 0, 0, 7, 7, 2, 2, 0, 1);

        nRST = 1'b0;
        stage_data = {32'h0000_0011, 32'h0000_0042};
        drive(1, 0, 1, 1, 0, 3, 3, 3);
        #12;
        check("reset sel", 64'(fwd_sel), 64'h0);
        check("reset data", 64'(fwd_data), 64'h0);
        check("reset stall", 64'(stall), 64'h0);
        check("reset cnt", 64'(stall_cycles), 64'h0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].adv, vecs[i].fl, vecs[i].iv, vecs[i].iw, vecs[i].il,
                  int'(vecs[i].d), int'(vecs[i].s0), int'(vecs[i].s1));
            #2;
            check($sformatf("vec%0d sel0", i), 64'(fwd_sel[1:0]), 64'(vecs[i].sel0));
            check($sformatf("vec%0d sel1", i), 64'(fwd_sel[3:2]), 64'(vecs[i].sel1));
            check($sformatf("vec%0d data0", i), 64'(fwd_data[31:0]), 64'(exp_data(int'(vecs[i].sel0))));
            check($sformatf("vec%0d data1", i), 64'(fwd_data[63:32]), 64'(exp_data(int'(vecs[i].sel1))));
            check($sformatf("vec%0d stall", i), 64'(stall), 64'(vecs[i].stl));
            check($sformatf("vec%0d cnt", i), 64'(stall_cycles), 64'(vecs[i].cnt));
            tick();
        end

        // Freeze with a load-use hazard pending.
        drive(1, 0, 1, 1, 1, 7, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0, 7, 0);
        for (int c = 0; c < 5; c++) begin
            #2;
            chk_out($sformatf("freeze%0d", c), 0, 1'b1, 1);
            tick();
        end
        drive(1, 0, 1, 0, 0, 0, 7, 0);
        #2;
        chk_out("unfreeze", 0, 1'b1, 1);
        tick();
        #2;
        chk_out("after unfreeze", 2, 1'b0, 2);
        tick();

        // Flush while stalled, then flush discarding a real issue.
        drive(1, 0, 1, 1, 1, 7, 0, 0);
        tick();
        drive(1, 1, 1, 0, 0, 0, 7, 0);
        #2;
        chk_out("flush stall", 0, 1'b1, 2);
        tick();
        drive(1, 0, 1, 0, 0, 0, 7, 0);
        #2;
        chk_out("post flush", 2, 1'b0, 2);
        drive(1, 1, 1, 1, 0, 9, 0, 0);
        tick();
        drive(1, 0, 1, 0, 0, 0, 9, 0);
        #2;
        chk_out("flushed issue", 0, 1'b0, 2);
        tick();

        // Flush while frozen still kills the youngest entry.
        drive(1, 0, 1, 1, 1, 7, 0, 0);
        tick();
        drive(0, 1, 1, 0, 0, 0, 7, 0);
        #2;
        chk_out("frozen flush", 0, 1'b1, 2);
        tick();
        drive(0, 0, 1, 0, 0, 0, 7, 0);
        #2;
        chk_out("after frozen flush", 0, 1'b0, 2);
        tick();

        // Asynchronous reset between edges.
        drive(1, 0, 1, 1, 0, 4, 0, 0);
        tick();
        drive(1, 0, 1, 0, 0, 0, 4, 0);
        #2;
        chk_out("pre reset", 1, 1'b0, 2);
        nRST = 1'b0;
        #1;
        chk_out("async reset", 0, 1'b0, 0);
        nRST = 1'b1;
        tick();

        // Randomised run against the reference model.
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        pipe.delete();
        for (int i = 0; i < NSTAGES; i++) pipe.push_back('{default: 0});
        m_cnt = 32'h0;
        tick();
        for (int n = 0; n < NRAND; n++) begin
            int   sel [NREAD];
            bit   haz [NREAD];
            bit   e_stall;
            rec_t r;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            stage_data = {$urandom, $urandom};
            #2;
            e_stall = 1'b0;
            for (int p = 0; p < NREAD; p++) begin
                model_port(issue_src[5*p +: 5], sel[p], haz[p]);
                e_stall = e_stall | (issue_valid && haz[p]);
                check($sformatf("rnd%0d sel%0d", n, p), 64'(fwd_sel[SELW*p +: SELW]), 64'(sel[p]));
                check($sformatf("rnd%0d data%0d", n, p), 64'(fwd_data[DW*p +: DW]), 64'(exp_data(sel[p])));
            end
            check($sformatf("rnd%0d stall", n), 64'(stall), 64'(e_stall));
            check($sformatf("rnd%0d cnt", n), 64'(stall_cycles), 64'(m_cnt));

            if (advance) begin
                r = '{default: 0};
                if (issue_valid && !e_stall) begin
                    r.valid = 1'b1;
                    r.wen = issue_wen && issue_dest != 0;
                    r.is_load = issue_is_load;
                    r.dest = issue_dest;
                end
                pipe.push_front(r);
                void'(pipe.pop_back());
            end
            if (flush) begin
                for (int i = 0; i < FLUSH_DEPTH && i < NSTAGES; i++) pipe[i].valid = 1'b0;
            end
            if (e_stall && advance && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
